// File: rtl/hazard_ctrl_pkg.sv
// Shared definitions for the pipeline hazard sequencer: state encodings,
// forwarding selects, register-zero constant and a source-match helper.
package hazard_ctrl_pkg;

  localparam int unsigned REG_W = 5;
  localparam int unsigned FWD_W = 2;

  localparam logic [REG_W-1:0] REG_ZERO = 5'd0;

  typedef enum logic {
    ST_RUN     = 1'b0,
    ST_MD_WAIT = 1'b1
  } state_e;

  typedef enum logic [FWD_W-1:0] {
    FWD_REG = 2'd0,
    FWD_E   = 2'd1,
    FWD_M   = 2'd2
  } fwd_sel_e;

  // True when a used source register matches a non-zero destination
  function automatic logic src_match(input logic [REG_W-1:0] dest,
                                     input logic [REG_W-1:0] src,
                                     input logic             uses);
    return uses && (dest != REG_ZERO) && (dest == src);
  endfunction

endpackage

// File: rtl/hazard_ctrl_md_occupancy_timer.sv
// Mul/div occupancy down-counter. Loaded at issue with (cycles-1), decremented
// while the sequencer waits, cleared on abort. done_o flags the final wait cycle.
module md_occupancy_timer #(
  parameter int unsigned MUL_CYCLES = 4,
  parameter int unsigned DIV_CYCLES = 32
) (
  input  logic clk,
  input  logic reset,
  input  logic load_i,
  input  logic op_i,
  input  logic dec_i,
  input  logic abort_i,
  output logic done_o
);

  localparam int unsigned MAX_CYC = (DIV_CYCLES > MUL_CYCLES) ? DIV_CYCLES : MUL_CYCLES;
  localparam int unsigned TW      = (MAX_CYC > 2) ? $clog2(MAX_CYC) : 1;

  localparam logic [TW-1:0] MUL_LD = TW'(MUL_CYCLES - 1);
  localparam logic [TW-1:0] DIV_LD = TW'(DIV_CYCLES - 1);

  logic [TW-1:0] cnt_q;
  logic [TW-1:0] cnt_d;

  // Next count: abort clears, issue loads, waiting decrements toward zero
  always_comb begin
    cnt_d = cnt_q;
    if (abort_i) begin
      cnt_d = '0;
    end else if (load_i) begin
      cnt_d = op_i ? DIV_LD : MUL_LD;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - TW'(1);
    end
  end

  // Counter register
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // The decrement this cycle brings the count to zero
  assign done_o = (cnt_q <= TW'(1));

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard sequencer: stall/wipe control for PC, IF/ID and D/E,
// mul/div occupancy, optional forwarding selects, saturating stall counter.
// Optional feature: define FORWARDING_EN to generate forwarding selects
// (only load-use then stalls for RAW); otherwise RAW stalls until writeback.
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int unsigned MUL_CYCLES = 4,
  parameter int unsigned DIV_CYCLES = 32,
  parameter int unsigned CNT_W      = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [REG_W-1:0] d_rs,
  input  logic [REG_W-1:0] d_rt,
  input  logic             d_uses_rs,
  input  logic             d_uses_rt,
  input  logic             d_jump,
  input  logic             d_md_start,
  input  logic             d_md_op,
  input  logic [REG_W-1:0] e_dest,
  input  logic             e_reg_write,
  input  logic             e_mem_read,
  input  logic             e_branch_taken,
  input  logic [REG_W-1:0] m_dest,
  input  logic             m_reg_write,
  output logic             stall_f,
  output logic             stall_d,
  output logic             wipe_f,
  output logic             wipe_d,
  output logic [FWD_W-1:0] fwd_a,
  output logic [FWD_W-1:0] fwd_b,
  output logic             md_busy,
  output logic             md_abort,
  output logic [CNT_W-1:0] stall_cnt
);

  state_e           state_q;
  state_e           state_d;
  logic [CNT_W-1:0] stall_cnt_q;
  logic [CNT_W-1:0] stall_cnt_d;

  logic md_load;
  logic md_dec;
  logic md_clr;
  logic md_done;

  logic e_rs;
  logic e_rt;
  logic m_rs;
  logic m_rt;
  logic load_use;
  logic raw_stall;

  // Source/destination matches against the execute and memory stages
  assign e_rs = e_reg_write && src_match(e_dest, d_rs, d_uses_rs);
  assign e_rt = e_reg_write && src_match(e_dest, d_rt, d_uses_rt);
  assign m_rs = m_reg_write && src_match(m_dest, d_rs, d_uses_rs);
  assign m_rt = m_reg_write && src_match(m_dest, d_rt, d_uses_rt);

  assign load_use = e_mem_read && (e_rs || e_rt);

`ifdef FORWARDING_EN
  assign raw_stall = 1'b0;

  // Operand selects: non-load execute result beats memory result
  always_comb begin
    fwd_a = FWD_REG;
    fwd_b = FWD_REG;
    if (!reset) begin
      if (e_rs && !e_mem_read) begin
        fwd_a = FWD_E;
      end else if (m_rs) begin
        fwd_a = FWD_M;
      end
      if (e_rt && !e_mem_read) begin
        fwd_b = FWD_E;
      end else if (m_rt) begin
        fwd_b = FWD_M;
      end
    end
  end
`else
  // Without forwarding any pending write to a used source stalls decode
  assign raw_stall = e_rs || e_rt || m_rs || m_rt;
  assign fwd_a     = FWD_REG;
  assign fwd_b     = FWD_REG;
`endif

  md_occupancy_timer #(
    .MUL_CYCLES (MUL_CYCLES),
    .DIV_CYCLES (DIV_CYCLES)
  ) u_md_timer (
    .clk     (clk),
    .reset   (reset),
    .load_i  (md_load),
    .op_i    (d_md_op),
    .dec_i   (md_dec),
    .abort_i (md_clr),
    .done_o  (md_done)
  );

  // Prioritised next-state and stall/wipe decode
  always_comb begin
    state_d  = state_q;
    stall_f  = 1'b0;
    stall_d  = 1'b0;
    wipe_f   = 1'b0;
    wipe_d   = 1'b0;
    md_busy  = 1'b0;
    md_abort = 1'b0;
    md_load  = 1'b0;
    md_dec   = 1'b0;
    md_clr   = 1'b0;
    if (reset) begin
      wipe_f  = 1'b1;
      wipe_d  = 1'b1;
      state_d = ST_RUN;
    end else if (e_branch_taken) begin
      // The branch is older than any mul/div waiting in execute
      wipe_f = 1'b1;
      wipe_d = 1'b1;
      if (state_q == ST_MD_WAIT) begin
        md_abort = 1'b1;
        md_clr   = 1'b1;
        state_d  = ST_RUN;
      end
    end else if (state_q == ST_MD_WAIT) begin
      md_busy = 1'b1;
      stall_f = 1'b1;
      stall_d = 1'b1;
      wipe_d  = 1'b1;
      md_dec  = 1'b1;
      if (md_done) begin
        state_d = ST_RUN;
      end
    end else if (load_use || raw_stall) begin
      stall_f = 1'b1;
      stall_d = 1'b1;
      wipe_d  = 1'b1;
    end else if (d_jump) begin
      wipe_f = 1'b1;
    end else if (d_md_start) begin
      md_load = 1'b1;
      state_d = ST_MD_WAIT;
    end
  end

  // Saturating count of stalled fetch cycles
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stall_f && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
  end

  // State and counter registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_RUN;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl; expectations are hand-computed per cycle.
// A second instance with a 3-bit counter covers counter saturation.
module tb_hazard_ctrl;

  localparam int unsigned CNT_W = 16;
`ifdef FORWARDING_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] d_rs, d_rt, e_dest, m_dest;
  logic       d_uses_rs, d_uses_rt, d_jump, d_md_start, d_md_op;
  logic       e_reg_write, e_mem_read, e_branch_taken, m_reg_write;

  logic             stall_f, stall_d, wipe_f, wipe_d, md_busy, md_abort;
  logic [1:0]       fwd_a, fwd_b;
  logic [CNT_W-1:0] stall_cnt;

  logic       stall_f2, stall_d2, wipe_f2, wipe_d2, md_busy2, md_abort2;
  logic [1:0] fwd_a2, fwd_b2;
  logic [2:0] stall_cnt2;

  int n_chk   = 0;
  int n_pass  = 0;
  int exp_cnt = 0;

  always #5 clk = ~clk;

  hazard_ctrl #(.MUL_CYCLES(8), .DIV_CYCLES(32), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .d_rs(d_rs), .d_rt(d_rt),
    .d_uses_rs(d_uses_rs), .d_uses_rt(d_uses_rt), .d_jump(d_jump),
    .d_md_start(d_md_start), .d_md_op(d_md_op), .e_dest(e_dest),
    .e_reg_write(e_reg_write), .e_mem_read(e_mem_read),
    .e_branch_taken(e_branch_taken), .m_dest(m_dest), .m_reg_write(m_reg_write),
    .stall_f(stall_f), .stall_d(stall_d), .wipe_f(wipe_f), .wipe_d(wipe_d),
    .fwd_a(fwd_a), .fwd_b(fwd_b), .md_busy(md_busy), .md_abort(md_abort),
    .stall_cnt(stall_cnt)
  );

  hazard_ctrl #(.MUL_CYCLES(8), .DIV_CYCLES(32), .CNT_W(3)) dut_sat (
    .clk(clk), .reset(reset), .d_rs(d_rs), .d_rt(d_rt),
    .d_uses_rs(d_uses_rs), .d_uses_rt(d_uses_rt), .d_jump(d_jump),
    .d_md_start(d_md_start), .d_md_op(d_md_op), .e_dest(e_dest),
    .e_reg_write(e_reg_write), .e_mem_read(e_mem_read),
    .e_branch_taken(e_branch_taken), .m_dest(m_dest), .m_reg_write(m_reg_write),
    .stall_f(stall_f2), .stall_d(stall_d2), .wipe_f(wipe_f2), .wipe_d(wipe_d2),
    .fwd_a(fwd_a2), .fwd_b(fwd_b2), .md_busy(md_busy2), .md_abort(md_abort2),
    .stall_cnt(stall_cnt2)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic idle();
    d_rs = '0; d_rt = '0; d_uses_rs = 0; d_uses_rt = 0; d_jump = 0;
    d_md_start = 0; d_md_op = 0; e_dest = '0; e_reg_write = 0; e_mem_read = 0;
    e_branch_taken = 0; m_dest = '0; m_reg_write = 0;
  endtask

  // Advance to just after the next rising edge
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1;
    idle();
    repeat (2) @(posedge clk);
    #3;
    check("rst_wipe_f", 32'(wipe_f), 1);
    check("rst_wipe_d", 32'(wipe_d), 1);
    check("rst_stall_f", 32'(stall_f), 0);
    check("rst_stall_d", 32'(stall_d), 0);
    check("rst_md_busy", 32'(md_busy), 0);
    check("rst_fwd_a", 32'(fwd_a), 0);
    check("rst_cnt", 32'(stall_cnt), 0);

    cyc(); reset = 1'b0; idle(); #2;
    check("run_wipe_f", 32'(wipe_f), 0);
    check("run_wipe_d", 32'(wipe_d), 0);
    check("run_stall_f", 32'(stall_f), 0);

    // Load-use: one bubble
    cyc(); idle(); e_mem_read = 1; e_reg_write = 1; e_dest = 5; d_rs = 5; d_uses_rs = 1; #2;
    check("lu_stall_f", 32'(stall_f), 1);
    check("lu_stall_d", 32'(stall_d), 1);
    check("lu_wipe_d", 32'(wipe_d), 1);
    check("lu_wipe_f", 32'(wipe_f), 0);
    exp_cnt += 1;
    // Load now in M: forwarded, or one more stall without forwarding
    cyc(); idle(); m_reg_write = 1; m_dest = 5; d_rs = 5; d_uses_rs = 1; #2;
    check("lu_cnt", 32'(stall_cnt), 1);
    check("lu_m_stall", 32'(stall_f), 32'(!FWD));
    check("lu_m_fwd_a", 32'(fwd_a), FWD ? 2 : 0);
    exp_cnt += int'(!FWD);
    cyc(); idle(); e_mem_read = 1; e_reg_write = 1; e_dest = 5; d_rs = 5; d_rt = 5; #2;
    check("lu_unused_src", 32'(stall_f), 0);

    // ALU RAW through E then M
    cyc(); idle(); e_reg_write = 1; e_dest = 3; d_rt = 3; d_uses_rt = 1; #2;
    check("raw_e_stall", 32'(stall_f), 32'(!FWD));
    check("raw_e_fwd_b", 32'(fwd_b), FWD ? 1 : 0);
    exp_cnt += int'(!FWD);
    cyc(); idle(); m_reg_write = 1; m_dest = 3; d_rt = 3; d_uses_rt = 1; #2;
    check("raw_m_stall", 32'(stall_f), 32'(!FWD));
    check("raw_m_fwd_b", 32'(fwd_b), FWD ? 2 : 0);
    exp_cnt += int'(!FWD);
    cyc(); idle(); e_reg_write = 1; m_reg_write = 1; d_uses_rs = 1; d_uses_rt = 1; #2;
    check("r0_stall", 32'(stall_f), 0);
    check("r0_fwd_a", 32'(fwd_a), 0);
    check("r0_fwd_b", 32'(fwd_b), 0);
    cyc(); idle(); e_reg_write = 1; e_dest = 9; m_reg_write = 1; m_dest = 9; d_rs = 9; d_uses_rs = 1; #2;
    check("e_over_m_fwd_a", 32'(fwd_a), FWD ? 1 : 0);
    check("e_over_m_stall", 32'(stall_f), 32'(!FWD));
    exp_cnt += int'(!FWD);
    cyc(); idle(); #2;
    check("raw_cnt", 32'(stall_cnt), 32'(exp_cnt));

    // Divide: issue cycle then 31 wait cycles
    cyc(); idle(); d_md_start = 1; d_md_op = 1; #2;
    check("div_issue_stall", 32'(stall_f), 0);
    check("div_issue_wipe_d", 32'(wipe_d), 0);
    check("div_issue_busy", 32'(md_busy), 0);
    for (int i = 0; i < 31; i++) begin
      cyc(); idle(); #2;
      check("div_busy", 32'(md_busy), 1);
      check("div_stall", 32'(stall_f), 1);
    end
    exp_cnt += 31;
    cyc(); idle(); #2;
    check("div_done_busy", 32'(md_busy), 0);
    check("div_done_stall", 32'(stall_f), 0);
    check("div_cnt", 32'(stall_cnt), 32'(exp_cnt));
    check("cnt_saturate", 32'(stall_cnt2), 7);

    // Multiply with MUL_CYCLES=8: 7 wait cycles
    cyc(); idle(); d_md_start = 1; #2;
    check("mul_issue_busy", 32'(md_busy), 0);
    for (int i = 0; i < 7; i++) begin
      cyc(); idle(); #2;
      check("mul_busy", 32'(md_busy), 1);
    end
    exp_cnt += 7;
    cyc(); idle(); #2;
    check("mul_done_busy", 32'(md_busy), 0);

    // Abort on 5th wait cycle of a multiply
    cyc(); idle(); d_md_start = 1; #2;
    for (int i = 0; i < 4; i++) begin
      cyc(); idle(); #2;
      check("ab_busy", 32'(md_busy), 1);
    end
    exp_cnt += 4;
    cyc(); idle(); e_branch_taken = 1; #2;
    check("ab_pulse", 32'(md_abort), 1);
    check("ab_wipe_f", 32'(wipe_f), 1);
    check("ab_wipe_d", 32'(wipe_d), 1);
    check("ab_stall_f", 32'(stall_f), 0);
    cyc(); idle(); #2;
    check("ab_after_busy", 32'(md_busy), 0);
    check("ab_after_pulse", 32'(md_abort), 0);
    check("ab_after_stall", 32'(stall_f), 0);

    // Branch beats load-use and jump
    cyc(); idle(); e_branch_taken = 1; e_mem_read = 1; e_reg_write = 1; e_dest = 7;
    d_rs = 7; d_uses_rs = 1; d_jump = 1; #2;
    check("sim_wipe_f", 32'(wipe_f), 1);
    check("sim_wipe_d", 32'(wipe_d), 1);
    check("sim_stall_f", 32'(stall_f), 0);
    check("sim_stall_d", 32'(stall_d), 0);
    cyc(); idle(); d_jump = 1; #2;
    check("jmp_wipe_f", 32'(wipe_f), 1);
    check("jmp_wipe_d", 32'(wipe_d), 0);
    check("jmp_stall_f", 32'(stall_f), 0);

    // Load-use holds back a mul, which issues the next cycle
    cyc(); idle(); e_mem_read = 1; e_reg_write = 1; e_dest = 4; d_rt = 4; d_uses_rt = 1;
    d_md_start = 1; #2;
    check("lumd_stall", 32'(stall_f), 1);
    check("lumd_busy", 32'(md_busy), 0);
    exp_cnt += 1;
    cyc(); idle(); d_md_start = 1; #2;
    check("lumd_issue_stall", 32'(stall_f), 0);
    check("pre_rst_cnt", 32'(stall_cnt), 32'(exp_cnt));
    cyc(); idle(); #2;
    check("lumd_busy_next", 32'(md_busy), 1);

    // Reset mid-wait
    cyc(); reset = 1'b1; #2;
    check("mrst_wipe_f", 32'(wipe_f), 1);
    check("mrst_wipe_d", 32'(wipe_d), 1);
    check("mrst_stall_f", 32'(stall_f), 0);
    check("mrst_busy", 32'(md_busy), 0);
    cyc(); reset = 1'b0; #2;
    check("mrst_run_busy", 32'(md_busy), 0);
    check("mrst_run_stall", 32'(stall_f), 0);
    check("mrst_cnt", 32'(stall_cnt), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
